arb4_rr: RTL and testbench
==========================

ARB4_RR -- requirements
Module: arb4_rr

Interface
REQ-001 Parameter: p_nbits, default 32, width of every message port.
REQ-002 Port: clk  input  1  clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 Port: req_val  input  4  bit i = requester i presents a valid message.
REQ-005 Port: req_rdy  output  4  bit i = requester i's message accepted this cycle; at most one bit set.
REQ-006 Ports: req_msg0, req_msg1, req_msg2, req_msg3  input  p_nbits each  requester messages.
REQ-007 Port: out_val  output  1  output buffer holds a valid message.
REQ-008 Port: out_rdy  input  1  downstream accepts the output message this cycle.
REQ-009 Port: out_msg  output  p_nbits  buffered message.
REQ-010 Port: out_src  output  2  index of the requester that supplied out_msg.

Function
REQ-011 Block SHALL share one output channel among four requesters with val/rdy handshakes on both sides; transfer occurs on any cycle where val and rdy are both 1.
REQ-012 Message selection SHALL use a Mux4_RTL instance (p_nbits wide), with sel driven by the current grant index.
REQ-013 State: 1-entry output buffer (out_val, out_msg, out_src) plus a 2-bit round-robin pointer ptr.
REQ-014 Buffer states: EMPTY (out_val=0) and FULL (out_val=1); can_accept = !out_val || out_rdy.
REQ-015 Grant SHALL be combinational: when can_accept=1, winner = first i with req_val[i]=1 scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4); req_rdy = one-hot(winner); otherwise req_rdy=0.
REQ-016 req_rdy SHALL be 0 for all bits when no req_val bit is set or can_accept=0.
REQ-017 On an accepted request: next cycle out_val=1, out_msg=req_msg[winner], out_src=winner, ptr=winner+1 mod 4 (3 wraps to 0).
REQ-018 Latency: accepted message visible on out_msg exactly 1 cycle after acceptance; no combinational path from req_msg* to out_msg.
REQ-019 FULL and out_rdy=1 with no request: next cycle out_val=0; ptr unchanged.
REQ-020 FULL and out_rdy=1 with a request (simultaneous drain and fill): SHALL accept new winner the same cycle; out_val stays 1; throughput one message per cycle.
REQ-021 FULL and out_rdy=0: out_val, out_msg, out_src, ptr SHALL hold; req_rdy=0.
REQ-022 ptr SHALL change only on acceptance; idle cycles never advance it.
REQ-023 Fairness: with all four req_val held at 1 and out_rdy held at 1, grants SHALL rotate ptr order so each requester wins once in every 4 consecutive grants.
REQ-024 out_rdy SHALL not be required to depend on out_val; out_rdy while EMPTY is ignored.
REQ-025 out_msg and out_src while out_val=0 SHALL hold their last values (no requirement to clear).

Reset
REQ-026 reset=1 at a rising edge SHALL set out_val=0, out_msg=0, out_src=0, ptr=0, overriding any concurrent handshake.
REQ-027 While reset=1, req_rdy SHALL be 0 (no acceptance during reset).
REQ-028 Reset mid-operation SHALL discard a buffered message; first grant after reset SHALL start scanning at requester 0.

Verification
REQ-029 After reset, req_val=4'b1111, out_rdy=1, messages 0xA0..0xA3 -> out_src sequence 0,1,2,3,0 on consecutive cycles with out_msg 0xA0,0xA1,0xA2,0xA3,0xA0; req_rdy one-hot every cycle.
REQ-030 req_val=4'b0100 msg2=0x55, out_rdy=0 for 3 cycles -> req_rdy=4'b0100 once; out_val=1, out_msg=0x55, out_src=2 held 3 cycles; req_rdy=0 meanwhile; drain on out_rdy=1 -> out_val=0 next cycle.
REQ-031 ptr=3 (after a grant to 2), req_val=4'b1001 -> grant 3 then 0 (wrap-around), ptr ends at 1.
REQ-032 Buffer FULL, out_rdy=1, req_val=4'b0010 msg1=0x77 same cycle -> next cycle out_val=1, out_msg=0x77, out_src=1 (no bubble).
REQ-033 Buffer FULL with 0x33, reset=1 asserted with req_val=4'b1111, out_rdy=1 -> next cycle out_val=0, out_src=0, req_rdy=0 during reset; first post-reset grant to requester 0.
REQ-034 Random: 200 cycles, random req_val/out_rdy/messages, p_nbits=1, 5, 32 -> every message accepted appears exactly once on out_msg in order with matching out_src; scoreboard and round-robin reference model agree.

Source files
------------

// File: rtl/arb4_rr.sv
// Four-requester round-robin arbiter feeding a one-entry output buffer.
// Grant is combinational; the selected message is registered, so out_msg lags acceptance by one cycle.
module arb4_rr #(
    parameter int p_nbits = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         req_val,
    output logic [3:0]         req_rdy,
    input  logic [p_nbits-1:0] req_msg0,
    input  logic [p_nbits-1:0] req_msg1,
    input  logic [p_nbits-1:0] req_msg2,
    input  logic [p_nbits-1:0] req_msg3,
    output logic               out_val,
    input  logic               out_rdy,
    output logic [p_nbits-1:0] out_msg,
    output logic [1:0]         out_src
);

    logic               out_val_q, out_val_d;
    logic [p_nbits-1:0] out_msg_q, out_msg_d;
    logic [1:0]         out_src_q, out_src_d;
    logic [1:0]         ptr_q, ptr_d;

    logic [1:0]         winner;
    logic [1:0]         idx;
    logic               found;
    logic               can_accept;
    logic               grant;
    logic [p_nbits-1:0] mux_out;

    // A full buffer can still take a new message when it drains in the same cycle.
    assign can_accept = !out_val_q || out_rdy;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        winner = 2'd0;
        found  = 1'b0;
        idx    = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + k[1:0];
            if (!found && req_val[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign grant   = found && can_accept && !reset;
    assign req_rdy = grant ? (4'b0001 << winner) : 4'b0000;

    Mux4_RTL #(.p_nbits(p_nbits)) u_mux (
        .in0_i (req_msg0),
        .in1_i (req_msg1),
        .in2_i (req_msg2),
        .in3_i (req_msg3),
        .sel_i (winner),
        .out_o (mux_out)
    );

    always_comb begin
        out_val_d = out_val_q;
        out_msg_d = out_msg_q;
        out_src_d = out_src_q;
        ptr_d     = ptr_q;
        if (grant) begin
            out_val_d = 1'b1;
            out_msg_d = mux_out;
            out_src_d = winner;
            ptr_d     = winner + 2'd1;
        end else if (out_rdy) begin
            out_val_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
        if (reset) begin
            out_val_q <= 1'b0;
            out_msg_q <= '0;
            out_src_q <= 2'd0;
            ptr_q     <= 2'd0;
        end else begin
            out_val_q <= out_val_d;
            out_msg_q <= out_msg_d;
            out_src_q <= out_src_d;
            ptr_q     <= ptr_d;
        end
    end

    assign out_val = out_val_q;
    assign out_msg = out_msg_q;
    assign out_src = out_src_q;

endmodule

module Mux4_RTL #(
    parameter int p_nbits = 32
) (
    input  logic [p_nbits-1:0] in0_i,
    input  logic [p_nbits-1:0] in1_i,
    input  logic [p_nbits-1:0] in2_i,
    input  logic [p_nbits-1:0] in3_i,
    input  logic [1:0]         sel_i,
    output logic [p_nbits-1:0] out_o
);

    always_comb begin
        out_o = in0_i;
        unique case (sel_i)
            2'd0: out_o = in0_i;
            2'd1: out_o = in1_i;
            2'd2: out_o = in2_i;
            2'd3: out_o = in3_i;
        endcase
    end

endmodule

// File: tb/tb_arb4_rr.sv
// Directed and random stimulus for arb4_rr at 32, 5 and 1 bit widths sharing one control stream;
// a round-robin reference model and a message scoreboard supply every expected value.
module tb_arb4_rr;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_val;
    logic        out_rdy;
    logic [31:0] m0, m1, m2, m3;

    logic [3:0]  req_rdy32, req_rdy5, req_rdy1;
    logic        out_val32, out_val5, out_val1;
    logic [31:0] out_msg32;
    logic [4:0]  out_msg5;
    logic [0:0]  out_msg1;
    logic [1:0]  out_src32, out_src5, out_src1;

    always #5 clk = ~clk;

    arb4_rr #(.p_nbits(32)) u_dut32 (
        .clk(clk), .reset(reset), .req_val(req_val), .req_rdy(req_rdy32),
        .req_msg0(m0), .req_msg1(m1), .req_msg2(m2), .req_msg3(m3),
        .out_val(out_val32), .out_rdy(out_rdy), .out_msg(out_msg32), .out_src(out_src32)
    );

    arb4_rr #(.p_nbits(5)) u_dut5 (
        .clk(clk), .reset(reset), .req_val(req_val), .req_rdy(req_rdy5),
        .req_msg0(m0[4:0]), .req_msg1(m1[4:0]), .req_msg2(m2[4:0]), .req_msg3(m3[4:0]),
        .out_val(out_val5), .out_rdy(out_rdy), .out_msg(out_msg5), .out_src(out_src5)
    );

    arb4_rr #(.p_nbits(1)) u_dut1 (
        .clk(clk), .reset(reset), .req_val(req_val), .req_rdy(req_rdy1),
        .req_msg0(m0[0:0]), .req_msg1(m1[0:0]), .req_msg2(m2[0:0]), .req_msg3(m3[0:0]),
        .out_val(out_val1), .out_rdy(out_rdy), .out_msg(out_msg1), .out_src(out_src1)
    );

    typedef struct packed {
        logic [1:0]  src;
        logic [31:0] msg;
    } entry_t;

    entry_t      sb[$];
    int          total = 0;
    int          bad = 0;

    logic        m_val = 1'b0;
    logic [31:0] m_msg = 32'd0;
    logic [1:0]  m_src = 2'd0;
    logic [1:0]  m_ptr = 2'd0;
    logic [3:0]  obs_rdy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pick(input logic [1:0] w);
        case (w)
            2'd0:    return m0;
            2'd1:    return m1;
            2'd2:    return m2;
            default: return m3;
        endcase
    endfunction

    // Drive one cycle of inputs, compare against the model, then advance the model across the edge.
    task automatic step(input logic rst, input logic [3:0] v, input logic ordy,
                        input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] a2, input logic [31:0] a3);
        logic       found;
        logic [1:0] w;
        logic [1:0] j;
        logic       gnt;
        logic [3:0] exp_rdy;
        entry_t     e;
        reset = rst; req_val = v; out_rdy = ordy;
        m0 = a0; m1 = a1; m2 = a2; m3 = a3;
        #1;
        found = 1'b0;
        w = 2'd0;
        for (int k = 0; k < 4; k++) begin
            j = m_ptr + 2'(k);
            if (!found && v[j]) begin
                found = 1'b1;
                w = j;
            end
        end
        gnt = found && (!m_val || ordy) && !rst;
        exp_rdy = gnt ? (4'b0001 << w) : 4'b0000;
        check("req_rdy32", 32'(req_rdy32), 32'(exp_rdy));
        check("req_rdy5", 32'(req_rdy5), 32'(exp_rdy));
        check("req_rdy1", 32'(req_rdy1), 32'(exp_rdy));
        check("out_val32", 32'(out_val32), 32'(m_val));
        check("out_val5", 32'(out_val5), 32'(m_val));
        check("out_val1", 32'(out_val1), 32'(m_val));
        if (m_val) begin
            if (sb.size() == 0) begin
                check("sb_nonempty", 32'(sb.size()), 32'd1);
            end else begin
                e = sb[0];
                check("sb_msg32", out_msg32, e.msg);
                check("sb_msg5", 32'(out_msg5), 32'(e.msg[4:0]));
                check("sb_msg1", 32'(out_msg1), 32'(e.msg[0]));
                check("sb_src32", 32'(out_src32), 32'(e.src));
                check("sb_src5", 32'(out_src5), 32'(e.src));
                check("sb_src1", 32'(out_src1), 32'(e.src));
            end
        end else begin
            check("idle_msg32", out_msg32, m_msg);
            check("idle_src32", 32'(out_src32), 32'(m_src));
        end
        obs_rdy = req_rdy32;
        if (rst) begin
            m_val = 1'b0; m_msg = 32'd0; m_src = 2'd0; m_ptr = 2'd0;
            sb.delete();
        end else begin
            if (m_val && ordy) begin
                void'(sb.pop_front());
                m_val = 1'b0;
            end
            if (gnt) begin
                e.src = w;
                e.msg = pick(w);
                sb.push_back(e);
                m_val = 1'b1; m_msg = e.msg; m_src = w; m_ptr = w + 2'd1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; req_val = 4'b0000; out_rdy = 1'b0;
        m0 = 32'd0; m1 = 32'd0; m2 = 32'd0; m3 = 32'd0;
        obs_rdy = 4'b0000;
        @(posedge clk);
        @(negedge clk);

        // Reset held with all requesters active: nothing may be accepted.
        step(1'b1, 4'b1111, 1'b1, 32'h1, 32'h2, 32'h3, 32'h4);
        check("rst_rdy", 32'(obs_rdy), 32'h0);
        check("rst_val", 32'(out_val32), 32'h0);
        check("rst_msg", out_msg32, 32'h0);
        check("rst_src", 32'(out_src32), 32'h0);

        // Full-load rotation starting at requester 0.
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 4'b1111, 1'b1, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
            check("rr_onehot", 32'($countones(obs_rdy)), 32'd1);
            check("rr_src", 32'(out_src32), 32'(i % 4));
            check("rr_msg", out_msg32, 32'hA0 + 32'(i % 4));
        end
        step(1'b0, 4'b0000, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0);
        check("drain_val", 32'(out_val32), 32'h0);

        // Single requester, downstream stalled for three cycles.
        step(1'b0, 4'b0100, 1'b0, 32'h0, 32'h0, 32'h55, 32'h0);
        check("stall_grant", 32'(obs_rdy), 32'b0100);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'b0100, 1'b0, 32'h0, 32'h0, 32'h55, 32'h0);
            check("stall_rdy", 32'(obs_rdy), 32'h0);
            check("stall_val", 32'(out_val32), 32'h1);
            check("stall_msg", out_msg32, 32'h55);
            check("stall_src", 32'(out_src32), 32'd2);
        end
        step(1'b0, 4'b0000, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0);
        check("stall_drain", 32'(out_val32), 32'h0);

        // Pointer at 3: grant 3, then wrap to 0, leaving the pointer at 1.
        step(1'b0, 4'b1001, 1'b1, 32'h10, 32'h0, 32'h0, 32'h13);
        check("wrap_g3", 32'(obs_rdy), 32'b1000);
        check("wrap_src3", 32'(out_src32), 32'd3);
        step(1'b0, 4'b1001, 1'b1, 32'h10, 32'h0, 32'h0, 32'h13);
        check("wrap_g0", 32'(obs_rdy), 32'b0001);
        check("wrap_src0", 32'(out_src32), 32'd0);
        step(1'b0, 4'b0011, 1'b1, 32'h20, 32'h21, 32'h0, 32'h0);
        check("ptr_at1", 32'(obs_rdy), 32'b0010);

        // Drain and refill in the same cycle: no bubble.
        step(1'b0, 4'b0010, 1'b1, 32'h0, 32'h77, 32'h0, 32'h0);
        check("fill_rdy", 32'(obs_rdy), 32'b0010);
        check("fill_val", 32'(out_val32), 32'h1);
        check("fill_msg", out_msg32, 32'h77);
        check("fill_src", 32'(out_src32), 32'd1);

        // Reset discards a buffered message and restarts the scan at requester 0.
        step(1'b0, 4'b0001, 1'b1, 32'h33, 32'h0, 32'h0, 32'h0);
        check("pre_rst_msg", out_msg32, 32'h33);
        step(1'b1, 4'b1111, 1'b1, 32'hB0, 32'hB1, 32'hB2, 32'hB3);
        check("mid_rst_rdy", 32'(obs_rdy), 32'h0);
        check("mid_rst_val", 32'(out_val32), 32'h0);
        check("mid_rst_src", 32'(out_src32), 32'h0);
        step(1'b0, 4'b1111, 1'b1, 32'hB0, 32'hB1, 32'hB2, 32'hB3);
        check("post_rst_g0", 32'(obs_rdy), 32'b0001);

        // Random traffic with occasional downstream stalls.
        for (int i = 0; i < 200; i++) begin
            step(1'b0, 4'($urandom), ($urandom_range(0, 3) != 0),
                 $urandom, $urandom, $urandom, $urandom);
        end
        step(1'b0, 4'b0000, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0);
        check("final_idle", 32'(out_val32), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
